usb_packet_router: RTL
======================

Name: usb_packet_router

Overview:
- Sits between the FT245 simple-interface RX byte stream and the per-channel sample FIFOs feeding one or more modulators.
- Parses a framed byte protocol, handling two kinds of packet:
  - Data packets: bytes are assembled into SAMPLE_BYTES-wide samples and steered to one of NUM_CH channel outputs with valid/ready.
  - Config packets: update a mode register.
- Provides inactivity timeout recovery and an error counter.

Parameters:
- SAMPLE_BYTES, 1, bytes per sample (1..4); little-endian packing.
- NUM_CH, 2, number of output channels (1..16).
- TIMEOUT_CLKS, 65535, idle cycles allowed mid-packet before abort (2..65535).
- MODE_RESET, 8'h00, reset value of mode_o.

Ports:
- clk  in  1  system clock (single domain).
- rst  in  1  asynchronous active-low reset.
- byte_data  in  8  RX byte from FT245 wrapper.
- byte_valid  in  1  byte_data valid.
- byte_ready  out  1  router accepts byte; a transfer occurs when byte_valid & byte_ready.
- smp_data  out  8*SAMPLE_BYTES  assembled sample, shared by all channels.
- smp_valid  out  NUM_CH  one-hot sample valid.
- smp_ready  in  NUM_CH  per-channel sink ready (typically !fifo_full).
- mode_o  out  8  config/mode register.
- err_count  out  8  saturating protocol error count.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (rst=0, asynchronous), then held until release:
  - state=IDLE, smp_valid=0, smp_data=0, mode_o=MODE_RESET, err_count=0, busy=0.
  - Internal byte index, sample counter, channel register and timeout counter all cleared.
  - byte_ready is combinational from state and is therefore 1 in IDLE.
- Packet format:
  - Header byte: bit7=1 is data, bit7=0 is config. Bits[3:0] hold the channel (data) or are ignored (config).
  - Data packet: header, LEN byte (samples-1, so 1..256 samples), then (LEN+1)*SAMPLE_BYTES payload bytes.
  - Config packet: header, then one value byte.
- States:
  - IDLE: accepted byte with bit7=1 latches channel ch_q=byte[3:0].
    - If ch_q < NUM_CH, go to LEN.
    - Otherwise go to LEN with a drop flag set, and increment err_count.
    - Accepted byte with bit7=0 goes to CFG.
  - CFG: accepted byte is written to mode_o on the same edge; return to IDLE.
  - LEN: latch remaining=LEN.
    - Go to PAYLOAD, or to DROP if the drop flag is set.
    - DROP consumes (LEN+1)*SAMPLE_BYTES bytes.
  - PAYLOAD:
    - Byte k of a sample goes into assembly bits [8k+7:8k].
    - On acceptance of the last byte (k=SAMPLE_BYTES-1), the sample is loaded into smp_data and smp_valid[ch_q] rises on the following cycle.
    - After the last byte of the last sample, return to IDLE.
  - DROP: byte_ready=1; bytes are discarded; return to IDLE after the count is exhausted.
- Output handshake:
  - smp_valid[ch_q] and smp_data are held stable until smp_ready[ch_q]=1.
  - smp_valid clears on the handshake edge unless a new sample completes on that same edge; in that case valid stays high with the new data (back-to-back, 1 sample/SAMPLE_BYTES cycles).
- Backpressure: in PAYLOAD, byte_ready = !(pending & !smp_ready[ch_q]).
  - The router never overwrites a pending sample.
  - byte_ready has no combinational path from byte_valid.
- Latency: the last payload byte accepted on cycle N gives smp_valid on N+1.
- Timeout:
  - The counter runs only when state != IDLE and byte_ready=1 and byte_valid=0.
  - It clears on any accepted byte and holds while byte_ready=0.
  - On reaching TIMEOUT_CLKS-1: go to IDLE, increment err_count, and discard the partial sample.
  - An already-pending complete sample is still delivered.
- err_count saturates at 255 (no wrap).
- Reset mid-packet: everything returns to reset values immediately; a pending sample is lost.
- Channel index uses bits[3:0]; values >= NUM_CH are errors even when NUM_CH=16 cannot produce one.

Test Plan:
- Config write: bytes 0x00,0x5A → mode_o=0x5A one cycle after the second byte; busy back to 0; err_count=0.
- SAMPLE_BYTES=2, NUM_CH=2, all smp_ready=1:
  - Stimulus: bytes 0x81,0x01,0x34,0x12,0x78,0x56.
  - smp_valid=2'b10 with smp_data=0x1234, then with 0x5678; returns to IDLE.
- Backpressure:
  - Stimulus: same packet with smp_ready[1]=0 for 20 cycles.
  - First sample held stable; byte_ready=0 while pending, and timeout does not fire.
  - After release, both samples are delivered in order and none are lost.
- Bad channel:
  - Stimulus: bytes 0x85,0x00,0xAA,0xBB with NUM_CH=2.
  - No smp_valid; err_count=1; the next valid packet routes correctly.
- Timeout with TIMEOUT_CLKS=16:
  - Stimulus: send 0x80,0x03,0x11 and then stop.
  - After 15 idle cycles: state IDLE, err_count=1, no partial sample output.
- Async reset:
  - Stimulus: assert rst=0 mid-PAYLOAD between clock edges.
  - Outputs clear immediately; err_count=0; mode_o=MODE_RESET; byte_ready=1 after release.

Source files
------------

// File: rtl/usb_packet_router.sv
`default_nettype none
// ============================================================================
// usb_packet_router : FT245 byte-stream parser that builds channel samples and mode writes
// Rev 1.0
// ============================================================================
module usb_packet_router #(
    parameter int         SAMPLE_BYTES = 1,
    parameter int         NUM_CH       = 2,
    parameter int         TIMEOUT_CLKS = 65535,
    parameter logic [7:0] MODE_RESET   = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                byte_data,
    input  logic                      byte_valid,
    output logic                      byte_ready,
    output logic [8*SAMPLE_BYTES-1:0] smp_data,
    output logic [NUM_CH-1:0]         smp_valid,
    input  logic [NUM_CH-1:0]         smp_ready,
    output logic [7:0]                mode_o,
    output logic [7:0]                err_count,
    output logic                      busy
);

    localparam int         SW         = 8 * SAMPLE_BYTES;
    localparam logic [1:0] c_LAST_K   = 2'(SAMPLE_BYTES - 1);
    localparam logic [4:0] c_NUM_CH   = 5'(NUM_CH);
    localparam logic [15:0] c_TO_LIMIT = 16'(TIMEOUT_CLKS - 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CFG     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_DROP    = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_ch;
    logic            r_drop;
    logic [7:0]      r_remaining;
    logic [1:0]      r_k;
    logic [SW-1:0]   r_asm;
    logic [15:0]     r_to_cnt;

    logic            w_accept;
    logic            w_pending;
    logic            w_hs;
    logic            w_to_run;
    logic            w_to_fire;
    logic            w_last_byte;
    logic            w_last_sample;
    logic            w_ch_ok;
    logic            w_bad_hdr;
    logic            w_err_inc;
    logic            w_smp_done;
    logic [SW-1:0]   w_asm_next;
    logic [NUM_CH-1:0] w_ch_onehot;

    // A pending sample blocks payload bytes unless it is being taken this cycle,
    // so a completed sample can never overwrite one that has not been handed off.
    assign w_pending     = |smp_valid;
    assign w_hs          = |(smp_valid & smp_ready);
    assign byte_ready    = (r_state != S_PAYLOAD) || !(w_pending && !w_hs);
    assign w_accept      = byte_valid && byte_ready;
    assign busy          = (r_state != S_IDLE);

    assign w_last_byte   = (r_k == c_LAST_K);
    assign w_last_sample = (r_remaining == 8'd0);
    assign w_ch_ok       = ({1'b0, byte_data[3:0]} < c_NUM_CH);
    assign w_bad_hdr     = (r_state == S_IDLE) && w_accept && byte_data[7] && !w_ch_ok;
    assign w_to_run      = (r_state != S_IDLE) && byte_ready && !byte_valid;
    assign w_to_fire     = w_to_run && (r_to_cnt == c_TO_LIMIT);
    assign w_err_inc     = w_bad_hdr || w_to_fire;
    assign w_smp_done    = (r_state == S_PAYLOAD) && w_accept && w_last_byte;

    always_comb begin
        w_ch_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (r_ch == 4'(i)) w_ch_onehot[i] = 1'b1;
        end
        w_asm_next = r_asm;
        for (int i = 0; i < SAMPLE_BYTES; i++) begin
            if (r_k == 2'(i)) w_asm_next[8*i +: 8] = byte_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = byte_data[7] ? S_LEN : S_CFG;
            end
            S_CFG: begin
                if (w_accept) w_state_next = S_IDLE;
            end
            S_LEN: begin
                if (w_accept) w_state_next = r_drop ? S_DROP : S_PAYLOAD;
            end
            S_PAYLOAD, S_DROP: begin
                if (w_accept && w_last_byte && w_last_sample) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_to_fire) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ch        <= '0;
            r_drop      <= 1'b0;
            r_remaining <= '0;
            r_k         <= '0;
            r_asm       <= '0;
            r_to_cnt    <= '0;
            smp_data    <= '0;
            smp_valid   <= '0;
            mode_o      <= MODE_RESET;
            err_count   <= '0;
        end else begin
            if (w_accept || w_to_fire) begin
                r_to_cnt <= '0;
            end else if (w_to_run) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end

            if (w_hs) smp_valid <= '0;
            if (w_smp_done) begin
                smp_data  <= w_asm_next;
                smp_valid <= w_ch_onehot;
            end

            if (w_err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept && byte_data[7]) begin
                        r_ch   <= byte_data[3:0];
                        r_drop <= !w_ch_ok;
                    end
                end
                S_CFG: begin
                    if (w_accept) mode_o <= byte_data;
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_remaining <= byte_data;
                        r_k         <= '0;
                    end
                end
                S_PAYLOAD, S_DROP: begin
                    if (w_accept) begin
                        if (r_state == S_PAYLOAD) r_asm <= w_asm_next;
                        if (w_last_byte) begin
                            r_k <= '0;
                            if (!w_last_sample) r_remaining <= r_remaining - 8'd1;
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                end
                default: ;
            endcase

            // An abort throws away only the partial sample; a pending one still drains.
            if (w_to_fire) begin
                r_k   <= '0;
                r_asm <= '0;
            end
        end
    end

endmodule
`default_nettype wire
